// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared Hack platform constants for the fetch path and ROM, plus the helper
// that computes how many instruction slots are already claimed at an edge.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int unsigned HACK_ADDR_WIDTH = 15;
  localparam int unsigned HACK_WORD_WIDTH = 16;
  localparam int unsigned HACK_RESET_PC   = 0;
  localparam int unsigned HACK_ROM_DEPTH  = 1 << HACK_ADDR_WIDTH;

  // Fetch buffer depth; the issue rule below is written for exactly two slots.
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  // Slots that will be occupied after this edge if nothing new is issued:
  // buffered entries plus the word still coming back from the ROM, minus the
  // entry the CPU takes this cycle.
  function automatic logic [2:0] f_Committed_Slots(input logic [1:0] i_Count,
                                                   input logic       i_Inflight,
                                                   input logic       i_Pop);
    return {1'b0, i_Count} + {2'b00, i_Inflight} - {2'b00, i_Pop};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Two-entry FIFO of {PC, instruction} pairs sitting between the ROM capture
// point and the CPU. Clear has priority over push and pop.
//
// Ports:
//   i_CLK, i_RST_N        clock, asynchronous active-low reset
//   i_Push                write {i_Push_PC, i_Push_Data} at the tail
//   i_Pop                 drop the head entry
//   i_Clear               discard all entries
//   o_Count               number of valid entries (0..2)
//   o_Head_PC/o_Head_Data head entry (zero after reset)
// -----------------------------------------------------------------------------
module fetch_buffer #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_Push,
  input  logic                  i_Pop,
  input  logic                  i_Clear,
  input  logic [ADDR_WIDTH-1:0] i_Push_PC,
  input  logic [DATA_WIDTH-1:0] i_Push_Data,
  output logic [1:0]            o_Count,
  output logic [ADDR_WIDTH-1:0] o_Head_PC,
  output logic [DATA_WIDTH-1:0] o_Head_Data
);

  localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_WIDTH-1:0] r_Mem [2];
  logic                   r_Rd_Ptr;
  logic                   r_Wr_Ptr;
  logic [1:0]             r_Count;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_Mem[0] <= '0;
      r_Mem[1] <= '0;
      r_Rd_Ptr <= 1'b0;
      r_Wr_Ptr <= 1'b0;
      r_Count  <= 2'd0;
    end else if (i_Clear) begin
      r_Rd_Ptr <= 1'b0;
      r_Wr_Ptr <= 1'b0;
      r_Count  <= 2'd0;
    end else begin
      if (i_Push) begin
        r_Mem[r_Wr_Ptr] <= {i_Push_PC, i_Push_Data};
        r_Wr_Ptr        <= ~r_Wr_Ptr;
      end
      if (i_Pop) begin
        r_Rd_Ptr <= ~r_Rd_Ptr;
      end
      r_Count <= r_Count + {1'b0, i_Push} - {1'b0, i_Pop};
    end
  end

  assign o_Count                  = r_Count;
  assign {o_Head_PC, o_Head_Data} = r_Mem[r_Rd_Ptr];

  // The fetch controller never issues into a full buffer nor pops an empty one.
  a_no_overflow : assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    !(i_Push && !i_Pop && !i_Clear && (r_Count == 2'd2)));
  a_no_underflow : assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    !(i_Pop && !i_Clear && (r_Count == 2'd0)));

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Hack CPU fetch stage. Drives the synchronous instruction ROM, hides its
// one-cycle read latency behind a two-entry buffer and hands instructions to
// the CPU over a valid/ready handshake at one per cycle. Jump redirects flush
// everything already fetched.
//
// Ports:
//   i_CLK, i_RST_N     clock, asynchronous active-low reset
//   o_Rom_Address      registered ROM address (the fetch PC)
//   i_Rom_Data         ROM word for the address sampled at the previous edge
//   o_Instruction/o_PC buffer head and its address
//   o_Valid, i_Ready   handshake; an instruction is taken when both are high
//   i_Redirect         one-cycle jump request to i_Redirect_Target
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = HACK_ADDR_WIDTH,
  parameter int unsigned            DATA_WIDTH = HACK_WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(HACK_RESET_PC)
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  output logic [ADDR_WIDTH-1:0] o_Rom_Address,
  input  logic [DATA_WIDTH-1:0] i_Rom_Data,
  output logic [DATA_WIDTH-1:0] o_Instruction,
  output logic [ADDR_WIDTH-1:0] o_PC,
  output logic                  o_Valid,
  input  logic                  i_Ready,
  input  logic                  i_Redirect,
  input  logic [ADDR_WIDTH-1:0] i_Redirect_Target
);

  logic [ADDR_WIDTH-1:0] r_Fetch_PC;
  logic                  r_Inflight;
  logic [ADDR_WIDTH-1:0] r_Inflight_PC;

  logic [1:0]            w_Count;
  logic                  w_Pop;
  logic [2:0]            w_Committed;
  logic                  w_Issue;

  assign o_Valid     = (w_Count != 2'd0);
  assign w_Pop       = o_Valid & i_Ready;
  assign w_Committed = f_Committed_Slots(w_Count, r_Inflight, w_Pop);
  // Only issue when the returning word is guaranteed a free slot.
  assign w_Issue     = (w_Committed < 3'd2) & ~i_Redirect;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_Fetch_PC    <= RESET_PC;
      r_Inflight    <= 1'b0;
      r_Inflight_PC <= '0;
    end else if (i_Redirect) begin
      // The ROM word for the current address is dropped by clearing in-flight.
      r_Fetch_PC <= i_Redirect_Target;
      r_Inflight <= 1'b0;
    end else if (w_Issue) begin
      r_Inflight    <= 1'b1;
      r_Inflight_PC <= r_Fetch_PC;
      r_Fetch_PC    <= r_Fetch_PC + ADDR_WIDTH'(1);
    end else begin
      r_Inflight <= 1'b0;
    end
  end

  assign o_Rom_Address = r_Fetch_PC;

  // A pop coinciding with a redirect still counts for the CPU; the clear then
  // removes whatever is left.
  fetch_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fetch_buffer (
    .i_CLK       (i_CLK),
    .i_RST_N     (i_RST_N),
    .i_Push      (r_Inflight),
    .i_Pop       (w_Pop),
    .i_Clear     (i_Redirect),
    .i_Push_PC   (r_Inflight_PC),
    .i_Push_Data (i_Rom_Data),
    .o_Count     (w_Count),
    .o_Head_PC   (o_PC),
    .o_Head_Data (o_Instruction)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Scoreboarded bench: a reference model predicts the stream of PCs the CPU
// should accept (sequential from the last reset/jump target) and when o_Valid
// must be high; a negedge monitor pops and compares every accepted instruction.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc;
  logic          valid;
  logic          ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] target = '0;

  int checks = 0;
  int failures = 0;

  instruction_fetch #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (15'd0)
  ) dut (
    .i_CLK             (clk),
    .i_RST_N           (rst_n),
    .o_Rom_Address     (rom_addr),
    .i_Rom_Data        (rom_data),
    .o_Instruction     (instr),
    .o_PC              (pc),
    .o_Valid           (valid),
    .i_Ready           (ready),
    .i_Redirect        (redirect),
    .i_Redirect_Target (target)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 16'h1000 + {1'b0, a};
  endfunction

  // Synchronous ROM: one-cycle read latency.
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected accepted-PC stream and blanking window.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] next_pc = '0;
  int            blank = 2;

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      next_pc = '0;
      blank   = 2;
    end else if (redirect) begin
      exp_q.delete();
      next_pc = target;
      blank   = 2;
    end else if (blank > 0) begin
      blank--;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 15'd1;
    end
  end

  // Monitor: compares on every accept, checks valid and stall stability.
  logic          stall_q = 1'b0;
  logic [AW-1:0] stall_pc = '0;
  logic [DW-1:0] stall_instr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_window", {31'd0, valid}, {31'd0, blank == 0});
      if (stall_q && blank == 0) begin
        chk("stall_pc_hold", {17'd0, pc}, {17'd0, stall_pc});
        chk("stall_instr_hold", {16'd0, instr}, {16'd0, stall_instr});
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          logic [AW-1:0] e;
          e = exp_q.pop_front();
          chk("accept_pc", {17'd0, pc}, {17'd0, e});
          chk("accept_instr", {16'd0, instr}, {16'd0, rom_word(e)});
        end
      end
      stall_q     = valid && !ready;
      stall_pc    = pc;
      stall_instr = instr;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [AW-1:0] t, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (valid && pc == t) found = 1;
      else step();
    end
    chk("wait_pc_timeout", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (valid) found = 1;
      else step();
    end
    chk("wait_valid_timeout", {31'd0, found}, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_addr", {17'd0, rom_addr}, 32'd0);
    chk("rst_pc", {17'd0, pc}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);

    ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First valid exactly two edges after release.
    step();
    chk("lat_edge1_valid", {31'd0, valid}, 32'd0);
    step();
    chk("lat_edge2_valid", {31'd0, valid}, 32'd1);
    chk("lat_first_pc", {17'd0, pc}, 32'd0);
    chk("lat_first_instr", {16'd0, instr}, 32'h1000);

    // Stall with PC 3 at the head.
    wait_pc(15'd3, 10);
    ready = 1'b0;
    repeat (5) step();
    chk("stall_pc", {17'd0, pc}, 32'd3);
    chk("stall_instr", {16'd0, instr}, 32'h1003);
    chk("stall_rom_addr", {17'd0, rom_addr}, 32'd5);
    ready = 1'b1;
    repeat (4) step();

    // Redirect with the buffer full.
    ready = 1'b0;
    repeat (3) step();
    redirect = 1'b1;
    target   = 15'h0100;
    step();
    redirect = 1'b0;
    ready    = 1'b1;
    chk("redir_blank1", {31'd0, valid}, 32'd0);
    step();
    chk("redir_blank2", {31'd0, valid}, 32'd0);
    step();
    chk("redir_pc", {17'd0, pc}, 32'h0100);
    chk("redir_instr", {16'd0, instr}, 32'h1100);
    step();
    chk("redir_pc_next", {17'd0, pc}, 32'h0101);

    // Redirect in the same cycle PC 7 is popped.
    redirect = 1'b1;
    target   = 15'd5;
    step();
    redirect = 1'b0;
    wait_pc(15'd7, 10);
    redirect = 1'b1;
    target   = 15'h0030;
    step();
    redirect = 1'b0;
    chk("pop_redir_blank", {31'd0, valid}, 32'd0);
    wait_valid(5);
    chk("pop_redir_pc", {17'd0, pc}, 32'h0030);

    // Back-to-back redirects: last one wins.
    redirect = 1'b1;
    target   = 15'h0020;
    step();
    target   = 15'h0040;
    step();
    redirect = 1'b0;
    wait_valid(5);
    chk("b2b_pc", {17'd0, pc}, 32'h0040);

    // Top-of-memory target wraps to 0.
    redirect = 1'b1;
    target   = 15'h7FFF;
    step();
    redirect = 1'b0;
    wait_valid(5);
    chk("wrap_pc0", {17'd0, pc}, 32'h7FFF);
    chk("wrap_instr0", {16'd0, instr}, 32'h8FFF);
    step();
    chk("wrap_pc1", {17'd0, pc}, 32'h0000);
    step();
    chk("wrap_pc2", {17'd0, pc}, 32'h0001);

    // Asynchronous reset with the buffer full.
    ready = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    chk("async_rst_addr", {17'd0, rom_addr}, 32'd0);
    chk("async_rst_pc", {17'd0, pc}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    #1;
    wait_valid(5);
    chk("restart_pc", {17'd0, pc}, 32'd0);

    // Random traffic: stalls, sporadic and back-to-back redirects.
    for (int i = 0; i < 600; i++) begin
      ready    = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 11) == 0);
      target   = ($urandom_range(0, 3) == 0) ? 15'h7FFF : AW'($urandom);
      step();
    end
    redirect = 1'b0;
    ready    = 1'b1;
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage between the Hack CPU core and the synchronous instruction ROM.
- Drives the ROM address and absorbs the ROM's fixed one-cycle read latency.
- Presents instructions to the CPU with a valid/ready handshake, sustaining one instruction per cycle.
- Supports jump redirects that flush stale instructions.

Parameters:
- ADDR_WIDTH, 15, ROM address / PC width (32K words).
- DATA_WIDTH, 16, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- i_CLK  input  1  system clock, rising edge.
- i_RST_N  input  1  asynchronous active-low reset.
- o_Rom_Address  output  ADDR_WIDTH  address to ROM, registered.
- i_Rom_Data  input  DATA_WIDTH  ROM read data, valid the cycle after the address was sampled.
- o_Instruction  output  DATA_WIDTH  instruction at buffer head.
- o_PC  output  ADDR_WIDTH  address of o_Instruction.
- o_Valid  output  1  o_Instruction/o_PC valid.
- i_Ready  input  1  CPU accepts; pop = o_Valid & i_Ready.
- i_Redirect  input  1  one-cycle jump request.
- i_Redirect_Target  input  ADDR_WIDTH  jump destination.

Behaviour:
- Reset (async, any time): r_Fetch_PC=RESET_PC, o_Rom_Address=RESET_PC, in-flight flag=0, buffer empty, o_Valid=0, o_Instruction=0, o_PC=0.
- o_Rom_Address always equals r_Fetch_PC.
- The ROM samples o_Rom_Address every edge; samples that are not issues are ignored.
- Issue at an edge iff (occupancy + inflight − pop) < 2 and no redirect.
  - On issue: in-flight<=1, in-flight PC<=r_Fetch_PC, r_Fetch_PC<=r_Fetch_PC+1, wrapping 2^ADDR_WIDTH−1 -> 0.
  - Otherwise: in-flight<=0.
- Capture: if in-flight=1 at an edge, push {in-flight PC, i_Rom_Data} into the 2-entry buffer at that edge.
- Buffer: 2-entry FIFO; head drives o_Instruction/o_PC; o_Valid = occupancy≠0.
  - Simultaneous push and pop allowed.
  - The issue rule guarantees no overflow; an overflow is an assertion failure.
- Latency:
  - Reset release to first o_Valid: 2 edges (issue, capture).
  - Steady state with i_Ready=1: one instruction per cycle, consecutive PCs.
- Stall (i_Ready=0): o_Instruction/o_PC/o_Valid held stable; at most 2 entries buffered; issue stops until space frees.
- Redirect at edge E (priority over issue):
  - A pop asserted in the same cycle still completes; the CPU owns that instruction.
  - Buffer cleared, in-flight<=0 (the ROM word arriving after E is discarded), r_Fetch_PC<=i_Redirect_Target.
  - o_Valid=0 after E; the target is issued at E+1 and valid after E+2.
  - Redirects on back-to-back cycles: the last one wins; no stale instruction is ever presented.
- Redirect target 2^ADDR_WIDTH−1: fetches that word, then wraps to 0.
- Reset asserted mid-stall or mid-redirect: immediate return to reset state; no partial entries survive.

Decomposition:
- Shared include (alongside existing ROM constants): HACK_ADDR_WIDTH=15, HACK_WORD_WIDTH=16, HACK_RESET_PC=0.
- One sub-module: fetch_buffer, a 2-entry FIFO of {PC, instruction} with push, pop, clear, count and head outputs, async active-low reset.
- Issue/redirect control stays in instruction_fetch.

Test Plan:
- Reset release, i_Ready=1, ROM model preloaded word[n]=0x1000+n -> o_Valid rises after 2nd edge with PC 0 / 0x1000, then PC 1,2,3… every cycle with no bubbles.
- i_Ready=0 for 5 cycles starting when o_PC=3 -> o_PC stays 3, o_Instruction stays 0x1003, o_Rom_Address stops advancing at 5. On release, 3,4,5,6 are delivered with no skips or duplicates.
- i_Redirect with target 0x0100 while 2 entries are buffered -> o_Valid=0 for 2 cycles, then PC 0x0100 / 0x1100, 0x0101… No PC from the old stream appears after the redirect edge.
- Redirect in the same cycle as a pop of PC 7 -> PC 7 is consumed exactly once; next delivered PC is the target. Back-to-back redirects to 0x20 then 0x40 -> first delivered PC is 0x40.
- Redirect to 0x7FFF, i_Ready=1 -> PCs delivered 0x7FFF, 0x0000, 0x0001.
- Assert i_RST_N low mid-stream with buffer full -> o_Valid=0 and o_Rom_Address=0 immediately (asynchronously). After release, the stream restarts from PC 0.
